// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and the prefetch queue entry type.
package fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0600_2000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h7800_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; push and pop may coincide at any occupancy.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         clear,
  output fetch_entry_t                 head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t      mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // NOTE: storage has no reset; occupancy is tracked by count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: PC and request credit control in front of a DEPTH-entry prefetch queue.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int PC_STEP         = 4,
  parameter bit PROTOCOL_ASSERT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       restore,
  input  logic [ADDR_W-1:0]          restore_pc,
  input  logic                       inject_valid,
  input  logic [INSTR_W-1:0]         inject_instr,
  input  logic                       stall,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [INSTR_W-1:0]         mem_rdata,
  output logic                       instr_valid,
  output logic [INSTR_W-1:0]         instr,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic [ADDR_W-1:0]          current_pc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int CW = $clog2(DEPTH+1);

  logic              run;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;

  logic              flush;
  logic [ADDR_W-1:0] target;
  logic [CW:0]       credits_used;
  logic              issue;
  logic              resp;
  logic              drop;
  logic              push;
  logic              pop;
  logic              empty;
  fetch_entry_t      head;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ('{pc: resp_pc, instr: mem_rdata}),
    .pop       (pop),
    .clear     (flush),
    .head      (head),
    .empty     (empty),
    .count     (q_count)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    flush        = run & (redirect | restore);
    target       = restore ? restore_pc : redirect_pc;
    credits_used = {1'b0, q_count} + {1'b0, outstanding};
    mem_req      = run & ~flush & (credits_used < (CW+1)'(DEPTH));
    issue        = mem_req & mem_gnt;
    // Responses with nothing outstanding are protocol errors and are ignored.
    resp         = mem_rvalid & (outstanding != '0);
    drop         = resp & (flush | (discard != '0));
    push         = resp & ~drop;
    pop          = run & ~flush & ~empty & ~stall & ~inject_valid;
    instr_valid  = run & ~flush & (inject_valid | ~empty);
    instr        = NOP_INSTR;
    instr_pc     = fetch_pc;
    if (instr_valid && !inject_valid) begin
      instr    = head.instr;
      instr_pc = head.pc;
    end else if (instr_valid) begin
      instr    = inject_instr;
    end
  end

  assign mem_addr   = fetch_pc;
  assign current_pc = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      run <= 1'b1;
      if (flush) begin
        // Everything still in flight, bar a response landing now, belongs to the old stream.
        fetch_pc    <= target;
        resp_pc     <= target;
        outstanding <= outstanding - CW'(resp);
        discard     <= outstanding - CW'(resp);
      end else begin
        if (issue) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        if (push)  resp_pc  <= resp_pc + ADDR_W'(PC_STEP);
        if (drop)  discard  <= discard - 1'b1;
        outstanding <= outstanding + CW'(issue) - CW'(resp);
      end
    end
  end

  generate
    if (PROTOCOL_ASSERT) begin : g_protocol_check
      always_ff @(posedge clk) begin
        if (rst_n) begin
          assert (!(mem_rvalid && outstanding == '0))
            else $error("mem_rvalid with no request outstanding");
        end
      end
    end
  endgenerate

endmodule
